cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Synthesizable, parametrised retire-trace capture unit for the cpu_2432 system. It records one entry per retired instruction (PC, instruction word, C/Z/V/S flags, optional timestamp) into a circular buffer, arms on request, and freezes on a PC-match trigger after a programmable post-trigger count. A host or bench then drains the frozen buffer oldest-first through a one-cycle read port. It sits beside `cpu_0` inside `system`, fed from the retire-stage PC, instruction and PSR.

## Interface
Parameters:
- ADDR_W, 16: PC width.
- INSTR_W, 24: instruction word width.
- DEPTH_LOG2, 5: buffer holds 2^DEPTH_LOG2 entries.
- POST_TRIG, 8: entries captured after the trigger entry, in the range 0..2^DEPTH_LOG2-1.
- TS_W, 16: timestamp width.

Ports:
- i_clk, in, 1: clock. All state changes on the rising edge.
- i_rstb, in, 1: asynchronous active-low reset.
- i_clk_en, in, 1: clock enable. No state changes while it is low.
- i_valid, in, 1: retire strobe. The entry inputs are valid when it is high.
- i_pc, in, ADDR_W: retired PC.
- i_instr, in, INSTR_W: retired instruction.
- i_flags, in, 4: {C,Z,V,S}.
- i_arm, in, 1: clear the buffer and enter ARMED.
- i_trig_en, in, 1: enable the PC-match trigger.
- i_trig_pc, in, ADDR_W: trigger PC.
- i_rd_req, in, 1: pop the oldest entry.
- o_rd_valid, out, 1: read data valid.
- o_rd_pc, out, ADDR_W: read-data PC field.
- o_rd_instr, out, INSTR_W: read-data instruction field.
- o_rd_flags, out, 4: read-data flags field.
- o_rd_tstamp, out, TS_W: read-data timestamp field.
- o_state, out, 2: 0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE.
- o_count, out, DEPTH_LOG2+1: number of entries held.

## Operation
- Reset: state IDLE. Write pointer, read pointer, o_count, post counter and timestamp are all 0. o_rd_valid is 0 and every o_rd_* output is 0.
- In the statements below, "cycle" means a rising edge with i_clk_en=1.
- IDLE: nothing is captured. i_arm moves the state to ARMED and clears the pointers and o_count.
- ARMED:
  - Every i_valid writes an entry at the write pointer, then the write pointer increments modulo depth.
  - o_count saturates at 2^DEPTH_LOG2. When full, the oldest entry is overwritten and the read pointer advances with the write pointer.
  - Trigger condition: i_valid && i_trig_en && i_pc==i_trig_pc. The triggering entry is captured.
  - On trigger with POST_TRIG=0: go to DONE.
  - On trigger with POST_TRIG>0: go to TRIGGERED and load the post counter with POST_TRIG.
- TRIGGERED: each i_valid captures an entry and decrements the post counter. The capture that brings the counter to 0 moves the state to DONE. Trigger matches are ignored in this state.
- DONE:
  - Capture stops.
  - i_rd_req with o_count>0 reads the entry at the read pointer, increments the read pointer, and decrements o_count.
  - i_rd_req with o_count=0 is ignored and o_rd_valid stays 0.
  - The state stays DONE after the buffer is drained.
- i_rd_req in any state other than DONE is ignored.
- Priority: i_arm beats trigger, capture and read. An arm asserted in any state restarts the buffer in ARMED, and an i_valid in the same cycle is not captured.
- Timestamp: free-running counter that increments every cycle and wraps at 2^TS_W. Each entry records the counter value current at its capture.

## Timing
- Capture: the entry is written on the same edge that samples i_valid. o_count reflects it on the following cycle.
- Read latency: 1 cycle. o_rd_valid is a single-cycle pulse in the cycle after an accepted i_rd_req. The o_rd_* fields hold their last value while o_rd_valid is low.
- Back-to-back reads are accepted every cycle, giving 1 entry per cycle.
- A state transition caused by an event in cycle N is visible on o_state in cycle N+1.
- i_clk_en low freezes all state and the timestamp. o_rd_valid drops to 0 and stays 0 until the next enabled read.
- Reset asserted mid-capture or mid-read returns the block to IDLE immediately and discards the buffer contents.

## Configuration
- Macro: `CPU_TRACE_TSTAMP_EN`.
- Defined: the timestamp counter and the per-entry TS_W field are built, and o_rd_tstamp returns the captured value.
- Undefined: no counter and no storage for the field are built, and o_rd_tstamp is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then 10 cycles of i_valid with no arm -> o_state=0, o_count=0, o_rd_valid never asserts.
- Arm, then 5 retires at PC 0x0010..0x0014, no trigger -> o_count=5, o_state=1. Reads are ignored until DONE.
- DEPTH_LOG2=3, POST_TRIG=2. Arm, 20 retires at PC 0..19, trigger PC=12 -> DONE after PC 14. o_count=8. Eight reads return PCs 7..14 in order. A ninth read gives no o_rd_valid.
- POST_TRIG=0, trigger on the first retire PC=0x0100 -> o_state=3 next cycle, o_count=1. The read returns PC 0x0100 with the correct instr and flags.
- i_arm and a trigger-matching i_valid in the same cycle -> state ARMED, o_count=0, no capture.
- With `CPU_TRACE_TSTAMP_EN` defined, i_clk_en held low for 3 cycles between two retires -> their timestamps differ by the number of enabled cycles only. Without the macro, o_rd_tstamp=0 on every read.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - retire-trace capture buffer with PC-match trigger
//
// Records one entry per retired instruction (PC, instruction, {C,Z,V,S},
// optional timestamp) into a circular buffer while armed, freezes a
// programmable number of entries after a PC-match trigger, then lets the
// host drain the frozen buffer oldest-first through a one-cycle read port.
//
// Optional feature macro: CPU_TRACE_TSTAMP_EN builds the free-running
// timestamp counter and the per-entry timestamp field.
//
// Ports:
//   i_clk, i_rstb          clock, asynchronous active-low reset
//   i_clk_en               clock enable, freezes all state when low
//   i_valid, i_pc,
//   i_instr, i_flags       retire strobe and entry fields
//   i_arm                  clear buffer and enter ARMED
//   i_trig_en, i_trig_pc   PC-match trigger
//   i_rd_req               pop oldest entry (DONE only)
//   o_rd_valid, o_rd_*     registered read data, one-cycle valid pulse
//   o_state                0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
//   o_count                entries held
module cpu_trace_buffer #(
  parameter int ADDR_W     = 16,
  parameter int INSTR_W    = 24,
  parameter int DEPTH_LOG2 = 5,
  parameter int POST_TRIG  = 8,
  parameter int TS_W       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstb,
  input  logic                  i_clk_en,
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [INSTR_W-1:0]    i_instr,
  input  logic [3:0]            i_flags,
  input  logic                  i_arm,
  input  logic                  i_trig_en,
  input  logic [ADDR_W-1:0]     i_trig_pc,
  input  logic                  i_rd_req,
  output logic                  o_rd_valid,
  output logic [ADDR_W-1:0]     o_rd_pc,
  output logic [INSTR_W-1:0]    o_rd_instr,
  output logic [3:0]            o_rd_flags,
  output logic [TS_W-1:0]       o_rd_tstamp,
  output logic [1:0]            o_state,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] POST_LD  = DEPTH_LOG2'(POST_TRIG);
  localparam logic [DEPTH_LOG2-1:0] POST_ONE = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRIG  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q, post_q;
  logic [DEPTH_LOG2:0]     count_q;
  logic                    capture, trig_hit, rd_accept, full;

  logic [ADDR_W-1:0]       mem_pc    [DEPTH];
  logic [INSTR_W-1:0]      mem_instr [DEPTH];
  logic [3:0]              mem_flags [DEPTH];

  logic                    rd_valid_q;
  logic [ADDR_W-1:0]       rd_pc_q;
  logic [INSTR_W-1:0]      rd_instr_q;
  logic [3:0]              rd_flags_q;

  // Arm has priority over everything, so it masks capture and read.
  assign full      = (count_q == FULL_CNT);
  assign capture   = i_clk_en && !i_arm && i_valid &&
                     (state_q == S_ARMED || state_q == S_TRIG);
  assign trig_hit  = capture && (state_q == S_ARMED) && i_trig_en &&
                     (i_pc == i_trig_pc);
  assign rd_accept = i_clk_en && !i_arm && (state_q == S_DONE) &&
                     i_rd_req && (count_q != '0);

  always_comb begin
    state_d = state_q;
    if (i_clk_en) begin
      if (i_arm) begin
        state_d = S_ARMED;
      end else begin
        case (state_q)
          S_ARMED: if (trig_hit) state_d = (POST_TRIG == 0) ? S_DONE : S_TRIG;
          // The capture that takes the post counter from 1 to 0 ends the run.
          S_TRIG:  if (capture && post_q == POST_ONE) state_d = S_DONE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
    end else if (i_clk_en) begin
      state_q <= state_d;
      if (i_arm) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        post_q   <= '0;
      end else begin
        if (capture) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          // When full the oldest entry is overwritten, so the read pointer
          // follows the write pointer and the count stays saturated.
          if (full) rd_ptr_q <= rd_ptr_q + 1'b1;
          else      count_q  <= count_q + 1'b1;
        end
        if (trig_hit)                          post_q <= POST_LD;
        else if (capture && state_q == S_TRIG) post_q <= post_q - 1'b1;
        // Reads only happen in DONE, where capture is off.
        if (rd_accept) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          count_q  <= count_q - 1'b1;
        end
      end
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      mem_pc[wr_ptr_q]    <= i_pc;
      mem_instr[wr_ptr_q] <= i_instr;
      mem_flags[wr_ptr_q] <= i_flags;
    end
  end

  // o_rd_valid follows rd_accept even with the clock enable low so that the
  // pulse never stretches; the data fields hold between reads.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      rd_valid_q <= 1'b0;
      rd_pc_q    <= '0;
      rd_instr_q <= '0;
      rd_flags_q <= '0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_pc_q    <= mem_pc[rd_ptr_q];
        rd_instr_q <= mem_instr[rd_ptr_q];
        rd_flags_q <= mem_flags[rd_ptr_q];
      end
    end
  end

`ifdef CPU_TRACE_TSTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] mem_ts [DEPTH];
  logic [TS_W-1:0] rd_ts_q;

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb)       ts_q <= '0;
    else if (i_clk_en) ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (capture) mem_ts[wr_ptr_q] <= ts_q;
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb)        rd_ts_q <= '0;
    else if (rd_accept) rd_ts_q <= mem_ts[rd_ptr_q];
  end

  assign o_rd_tstamp = rd_ts_q;
`else
  assign o_rd_tstamp = '0;
`endif

  assign o_rd_valid = rd_valid_q;
  assign o_rd_pc    = rd_pc_q;
  assign o_rd_instr = rd_instr_q;
  assign o_rd_flags = rd_flags_q;
  assign o_state    = state_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - self-checking bench for cpu_trace_buffer
module tb_cpu_trace_buffer;

  localparam int DL   = 3;
  localparam int DEP  = 1 << DL;
  localparam int POST = 2;

  logic        clk = 1'b0;
  logic        rstb, clk_en, valid, arm, trig_en, rd_req;
  logic [15:0] pc, trig_pc;
  logic [23:0] instr;
  logic [3:0]  flags;

  logic        rd_valid,  d0_rd_valid;
  logic [15:0] rd_pc,     d0_rd_pc;
  logic [23:0] rd_instr,  d0_rd_instr;
  logic [3:0]  rd_flags,  d0_rd_flags;
  logic [15:0] rd_ts,     d0_rd_ts;
  logic [1:0]  state,     d0_state;
  logic [DL:0] count,     d0_count;

  always #5 clk = ~clk;

  cpu_trace_buffer #(.ADDR_W(16), .INSTR_W(24), .DEPTH_LOG2(DL), .POST_TRIG(POST), .TS_W(16)) u_dut (
    .i_clk(clk), .i_rstb(rstb), .i_clk_en(clk_en), .i_valid(valid), .i_pc(pc),
    .i_instr(instr), .i_flags(flags), .i_arm(arm), .i_trig_en(trig_en),
    .i_trig_pc(trig_pc), .i_rd_req(rd_req), .o_rd_valid(rd_valid), .o_rd_pc(rd_pc),
    .o_rd_instr(rd_instr), .o_rd_flags(rd_flags), .o_rd_tstamp(rd_ts),
    .o_state(state), .o_count(count));

  cpu_trace_buffer #(.ADDR_W(16), .INSTR_W(24), .DEPTH_LOG2(DL), .POST_TRIG(0), .TS_W(16)) u_dut0 (
    .i_clk(clk), .i_rstb(rstb), .i_clk_en(clk_en), .i_valid(valid), .i_pc(pc),
    .i_instr(instr), .i_flags(flags), .i_arm(arm), .i_trig_en(trig_en),
    .i_trig_pc(trig_pc), .i_rd_req(rd_req), .o_rd_valid(d0_rd_valid), .o_rd_pc(d0_rd_pc),
    .o_rd_instr(d0_rd_instr), .o_rd_flags(d0_rd_flags), .o_rd_tstamp(d0_rd_ts),
    .o_state(d0_state), .o_count(d0_count));

  typedef struct {
    logic [15:0] pc;
    logic [23:0] instr;
    logic [3:0]  flags;
    logic [15:0] ts;
  } ent_t;

  typedef struct {
    bit          ce;
    bit          arm;
    bit          valid;
    logic [15:0] pc;
    bit          rd;
    logic [1:0]  exp_state;
    logic [3:0]  exp_count;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_state;
  int          m_post;
  logic [15:0] m_ts;
  ent_t        m_q[$];
  ent_t        sb[$];
  logic [15:0] got_pcs[$];
  logic [15:0] got_ts[$];
  vec_t        tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_post  = 0;
    m_ts    = '0;
    m_q.delete();
    sb.delete();
  endtask

  task automatic model_push(input ent_t e);
    ent_t drop;
    if (m_q.size() == DEP) drop = m_q.pop_front();
    m_q.push_back(e);
  endtask

  // Reference behaviour of the POST=2 instance, evaluated on each rising edge.
  task automatic model_update();
    ent_t e;
    if (!rstb || !clk_en) return;
    e.pc = pc; e.instr = instr; e.flags = flags; e.ts = m_ts;
    if (arm) begin
      m_state = 1;
      m_post  = 0;
      m_q.delete();
    end else begin
      case (m_state)
        1: if (valid) begin
             model_push(e);
             if (trig_en && pc == trig_pc) begin
               if (POST == 0) m_state = 3;
               else begin m_state = 2; m_post = POST; end
             end
           end
        2: if (valid) begin
             model_push(e);
             m_post--;
             if (m_post == 0) m_state = 3;
           end
        3: if (rd_req && m_q.size() > 0) sb.push_back(m_q.pop_front());
        default: ;
      endcase
    end
    m_ts = m_ts + 16'd1;
  endtask

  task automatic step();
    ent_t e;
    bit   exp_v;
    @(posedge clk);
    model_update();
    #1;
    chk("state", state, m_state);
    chk("count", count, m_q.size());
    exp_v = (sb.size() != 0);
    chk("rd_valid", rd_valid, exp_v);
    if (exp_v) begin
      e = sb.pop_front();
      if (rd_valid) begin
        chk("rd_pc", rd_pc, e.pc);
        chk("rd_instr", rd_instr, e.instr);
        chk("rd_flags", rd_flags, e.flags);
`ifdef CPU_TRACE_TSTAMP_EN
        chk("rd_tstamp", rd_ts, e.ts);
`else
        chk("rd_tstamp", rd_ts, 0);
`endif
        got_pcs.push_back(rd_pc);
        got_ts.push_back(rd_ts);
      end
    end
  endtask

  task automatic drive(input bit ce, input bit a, input bit v, input logic [15:0] p, input bit rr);
    clk_en = ce;
    arm    = a;
    valid  = v;
    pc     = p;
    instr  = {8'hA5, p};
    flags  = p[3:0] ^ 4'h6;
    rd_req = rr;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 10; i++) begin
      tbl[i].ce = 1; tbl[i].arm = 0; tbl[i].valid = 1; tbl[i].pc = 16'h0050 + 16'(i);
      tbl[i].rd = 1; tbl[i].exp_state = 2'd0; tbl[i].exp_count = 4'd0;
    end
    tbl[10].ce = 1; tbl[10].arm = 1; tbl[10].valid = 0; tbl[10].pc = 16'h0;
    tbl[10].rd = 0; tbl[10].exp_state = 2'd1; tbl[10].exp_count = 4'd0;
    for (int i = 11; i < 16; i++) begin
      tbl[i].ce = 1; tbl[i].arm = 0; tbl[i].valid = 1; tbl[i].pc = 16'h0010 + 16'(i - 11);
      tbl[i].rd = 0; tbl[i].exp_state = 2'd1; tbl[i].exp_count = 4'(i - 10);
    end
    for (int i = 16; i < 18; i++) begin
      tbl[i].ce = 1; tbl[i].arm = 0; tbl[i].valid = 0; tbl[i].pc = 16'h0;
      tbl[i].rd = 1; tbl[i].exp_state = 2'd1; tbl[i].exp_count = 4'd5;
    end

    rstb = 0; clk_en = 1; valid = 0; arm = 0; trig_en = 0; rd_req = 0;
    pc = '0; trig_pc = '0; instr = '0; flags = '0;
    model_reset();
    #12;
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_fields", {rd_pc, rd_instr, rd_flags, rd_ts}, 0);
    chk("rst_d0_state", d0_state, 0);
    chk("rst_d0_rd", {d0_rd_valid, d0_rd_pc, d0_count}, 0);
    #1 rstb = 1;

    // Idle retires and reads are ignored; then arm and five retires.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].ce, tbl[i].arm, tbl[i].valid, tbl[i].pc, tbl[i].rd);
      chk("tbl_state", state, tbl[i].exp_state);
      chk("tbl_count", count, tbl[i].exp_count);
    end

    // Wrap plus trigger at PC 12 with two post-trigger entries.
    trig_en = 1; trig_pc = 16'd12;
    drive(1, 1, 0, 16'h0, 0);
    for (int p = 0; p < 20; p++) drive(1, 0, 1, 16'(p), 0);
    chk("wrap_state", state, 3);
    chk("wrap_count", count, 8);
    got_pcs.delete();
    for (int i = 0; i < 9; i++) drive(1, 0, 0, 16'h0, 1);
    chk("wrap_nreads", got_pcs.size(), 8);
    for (int i = 0; i < 8 && i < got_pcs.size(); i++) chk("wrap_order", got_pcs[i], 16'(7 + i));
    chk("wrap_read9", rd_valid, 0);
    chk("wrap_done_hold", state, 3);

    // POST_TRIG=0 instance: trigger on the first retire.
    trig_pc = 16'h0100;
    drive(1, 1, 0, 16'h0, 0);
    drive(1, 0, 1, 16'h0100, 0);
    chk("p0_state", d0_state, 3);
    chk("p0_count", d0_count, 1);
    drive(1, 0, 0, 16'h0, 1);
    chk("p0_rd_valid", d0_rd_valid, 1);
    chk("p0_rd_pc", d0_rd_pc, 16'h0100);
    chk("p0_rd_instr", d0_rd_instr, 24'hA50100);
    chk("p0_rd_flags", d0_rd_flags, 4'h6);
    chk("p0_count_after", d0_count, 0);
    drive(1, 0, 0, 16'h0, 0);
    chk("p0_rd_pulse", d0_rd_valid, 0);
    chk("p0_rd_hold", d0_rd_pc, 16'h0100);

    // Arm wins over a trigger-matching retire in the same cycle.
    trig_pc = 16'h0040;
    drive(1, 1, 1, 16'h0040, 0);
    chk("armtrig_state", state, 1);
    chk("armtrig_count", count, 0);
    chk("armtrig_d0_state", d0_state, 1);
    chk("armtrig_d0_count", d0_count, 0);

    // Clock enable low between two retires freezes state and timestamp.
    trig_pc = 16'h0031;
    drive(1, 1, 0, 16'h0, 0);
    drive(1, 0, 1, 16'h0030, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 16'h0099, 1);
    drive(1, 0, 1, 16'h0031, 0);
    drive(1, 0, 1, 16'h0032, 0);
    drive(1, 0, 1, 16'h0033, 0);
    chk("ce_state", state, 3);
    chk("ce_count", count, 4);
    got_pcs.delete();
    got_ts.delete();
    drive(1, 0, 0, 16'h0, 1);
    drive(1, 0, 0, 16'h0, 1);
    drive(0, 0, 0, 16'h0, 1);
    chk("ce_rd_blocked", rd_valid, 0);
    drive(1, 0, 0, 16'h0, 1);
    drive(1, 0, 0, 16'h0, 1);
    chk("ce_nreads", got_pcs.size(), 4);
    if (got_ts.size() >= 2) begin
`ifdef CPU_TRACE_TSTAMP_EN
      chk("ce_ts_delta", got_ts[1] - got_ts[0], 1);
`else
      chk("ce_ts_zero", {got_ts[0], got_ts[1]}, 0);
`endif
    end

    // Asynchronous reset mid-capture.
    drive(1, 1, 0, 16'h0, 0);
    drive(1, 0, 1, 16'h0070, 0);
    drive(1, 0, 1, 16'h0071, 0);
    #2 rstb = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_count", count, 0);
    chk("arst_rd", {rd_valid, rd_pc}, 0);
    model_reset();
    drive(1, 0, 1, 16'h0072, 0);
    #2 rstb = 1;
    drive(1, 0, 1, 16'h0073, 1);
    chk("arst_idle_state", state, 0);
    chk("arst_idle_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
